alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  synchronous active-low reset.
REQ-004 in_valid  in  1  decode request valid.
REQ-005 in_ready  out  1  request accepted when in_valid && in_ready.
REQ-006 in_instr  in  32  RV32I instruction word.
REQ-007 in_pc  in  32  instruction address.
REQ-008 in_rs1_data / in_rs2_data  in  32 each  register-file read values.
REQ-009 flush  in  1  discard all buffered and same-cycle requests.
REQ-010 out_valid  out  1  issued op valid.
REQ-011 out_ready  in  1  ALU stage accepts when out_valid && out_ready.
REQ-012 out_alu_ctl  out  5  ALU opcode in the ALU 5-bit encoding.
REQ-013 out_alu_a / out_alu_b  out  32 each  ALU operands.
REQ-014 out_rd  out  5  destination register (instr[11:7]), passed unchanged, x0 included.
REQ-015 out_illegal  out  1  unsupported opcode or funct.

Function
REQ-016 alu_ctl encoding SHALL be: ADD=1, SLT=2, SLTU=3, AND=4, OR=5, XOR=6, SLL=7, SRL=8, SUB=9, SRA=10, BEQ=11, BNE=12, BLT=13, BLTU=14, BGE=15, BGEU=16, LUI=17, ADDU=18; 0 = none.
REQ-017 OP (0110011): funct3/funct7 -> ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND; a=rs1, b=rs2; funct7 other than 0x00, or 0x20 with ADD/SRL, SHALL be illegal.
REQ-018 OP-IMM (0010011): ADDI->ADD, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI (funct7 0x20); a=rs1; b=sign-extended I-imm, shifts b=zero-extended shamt[4:0].
REQ-019 LUI (0110111) -> LUI, a=0, b={imm[31:12],12'b0}; AUIPC (0010111) -> ADDU, a=pc, b=U-imm.
REQ-020 BRANCH (1100011): funct3 000/001/100/101/110/111 -> BEQ/BNE/BLT/BGE/BLTU/BGEU; a=rs1, b=rs2; 010/011 illegal.
REQ-021 LOAD (0000011) -> ADDU, a=rs1, b=I-imm; STORE (0100011) -> ADDU, a=rs1, b=sign-extended S-imm.
REQ-022 JAL (1101111), JALR (1100111) -> ADDU, a=pc, b=4 (link value).
REQ-023 Any other opcode SHALL produce out_illegal=1, alu_ctl=0, a=b=0; the op still flows through the handshake.
REQ-024 Latency SHALL be exactly 1 cycle from acceptance to out_valid when the output stage is empty or draining.
REQ-025 Buffering SHALL be an output register plus one skid entry; in_ready SHALL be registered and equal "skid empty".
REQ-026 Accepted op SHALL load the output register if it is empty or out_ready=1 that cycle, otherwise the skid; skid SHALL move to the output register when the output drains.
REQ-027 Ordering SHALL be strict FIFO; no op lost or duplicated under any out_ready pattern.
REQ-028 Output payload SHALL remain stable while out_valid && !out_ready.
REQ-029 flush SHALL clear both valid bits next cycle, discard a same-cycle accepted request, and set in_ready=1 next cycle; flush has priority over accept and drain.

Reset
REQ-030 While rst_n=0 at a clock edge: out_valid=0, skid empty, all output payload fields=0, in_ready=0; in_ready=1 on the first cycle after rst_n=1.
REQ-031 Reset mid-transfer SHALL drop all buffered ops; no op issues after reset until newly accepted.

Structure
REQ-032 alu_ctl encodings, RV32I opcode constants and funct3/funct7 constants SHALL live in a shared package also used by the ALU.
REQ-033 Combinational decode SHALL be one sub-module, alu_decode (instr, pc, rs1, rs2 -> ctl, a, b, rd, illegal); alu_issue holds handshake and buffers.

Verification
REQ-034 ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle out_valid=1, ctl=1, a=5, b=7, rd=3, illegal=0.
REQ-035 SRAI x5,x6,4 (0x40435293), rs1=0x80000000 -> ctl=10, a=0x80000000, b=4, rd=5.
REQ-036 LUI x1,0x12345 (0x123450B7) -> ctl=17, a=0, b=0x12345000; AUIPC same imm, pc=0x100 -> ctl=18, a=0x100.
REQ-037 out_ready=0, three back-to-back valid ops -> two accepted, in_ready=0 from the cycle after the second is accepted, payload stable; release out_ready -> all three issue in order.
REQ-038 Instr 0x0000007F -> out_illegal=1, ctl=0, a=b=0.
REQ-039 flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing issues; repeat with rst_n=0 -> identical outcome.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared RV32I decode constants and ALU opcode encoding used by the issue stage and the ALU.
package alu_issue_pkg;

  typedef enum logic [4:0] {
    CTL_NONE = 5'd0,
    CTL_ADD  = 5'd1,
    CTL_SLT  = 5'd2,
    CTL_SLTU = 5'd3,
    CTL_AND  = 5'd4,
    CTL_OR   = 5'd5,
    CTL_XOR  = 5'd6,
    CTL_SLL  = 5'd7,
    CTL_SRL  = 5'd8,
    CTL_SUB  = 5'd9,
    CTL_SRA  = 5'd10,
    CTL_BEQ  = 5'd11,
    CTL_BNE  = 5'd12,
    CTL_BLT  = 5'd13,
    CTL_BLTU = 5'd14,
    CTL_BGE  = 5'd15,
    CTL_BGEU = 5'd16,
    CTL_LUI  = 5'd17,
    CTL_ADDU = 5'd18
  } alu_ctl_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef struct packed {
    logic [4:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        illegal;
  } issue_op_t;

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'b0};
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decode into ALU opcode and operands; unsupported encodings yield a zeroed illegal op.
module alu_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic [4:0]  ctl,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [4:0]  rd,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [31:0] shamt;
  alu_ctl_e   ctl_e;
  logic [31:0] a_raw;
  logic [31:0] b_raw;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign shamt  = {27'b0, instr[24:20]};
  assign rd     = instr[11:7];

  always_comb begin
    ctl_e   = CTL_NONE;
    a_raw   = rs1;
    b_raw   = rs2;
    illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD:  ctl_e = CTL_ADD;
            F3_SLL:  ctl_e = CTL_SLL;
            F3_SLT:  ctl_e = CTL_SLT;
            F3_SLTU: ctl_e = CTL_SLTU;
            F3_XOR:  ctl_e = CTL_XOR;
            F3_SR:   ctl_e = CTL_SRL;
            F3_OR:   ctl_e = CTL_OR;
            default: ctl_e = CTL_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          ctl_e = CTL_SUB;
        end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
          ctl_e = CTL_SRA;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        b_raw = imm_i(instr);
        case (funct3)
          F3_ADD:  ctl_e = CTL_ADD;
          F3_SLT:  ctl_e = CTL_SLT;
          F3_SLTU: ctl_e = CTL_SLTU;
          F3_XOR:  ctl_e = CTL_XOR;
          F3_OR:   ctl_e = CTL_OR;
          F3_AND:  ctl_e = CTL_AND;
          F3_SLL: begin
            b_raw = shamt;
            if (funct7 == F7_BASE) ctl_e = CTL_SLL;
            else illegal = 1'b1;
          end
          default: begin
            b_raw = shamt;
            if (funct7 == F7_BASE) ctl_e = CTL_SRL;
            else if (funct7 == F7_ALT) ctl_e = CTL_SRA;
            else illegal = 1'b1;
          end
        endcase
      end
      OPC_LUI: begin
        ctl_e = CTL_LUI;
        a_raw = 32'd0;
        b_raw = imm_u(instr);
      end
      OPC_AUIPC: begin
        ctl_e = CTL_ADDU;
        a_raw = pc;
        b_raw = imm_u(instr);
      end
      OPC_BRANCH: begin
        case (funct3)
          F3_BEQ:  ctl_e = CTL_BEQ;
          F3_BNE:  ctl_e = CTL_BNE;
          F3_BLT:  ctl_e = CTL_BLT;
          F3_BGE:  ctl_e = CTL_BGE;
          F3_BLTU: ctl_e = CTL_BLTU;
          F3_BGEU: ctl_e = CTL_BGEU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        ctl_e = CTL_ADDU;
        b_raw = imm_i(instr);
      end
      OPC_STORE: begin
        ctl_e = CTL_ADDU;
        b_raw = imm_s(instr);
      end
      OPC_JAL, OPC_JALR: begin
        // operands form the link address pc+4
        ctl_e = CTL_ADDU;
        a_raw = pc;
        b_raw = 32'd4;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign ctl = illegal ? CTL_NONE : ctl_e;
  assign a   = illegal ? 32'd0 : a_raw;
  assign b   = illegal ? 32'd0 : b_raw;

endmodule

// File: rtl/alu_issue.sv
// Issue stage: decodes accepted requests into an output register backed by one skid entry.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_alu_ctl,
  output logic [31:0] out_alu_a,
  output logic [31:0] out_alu_b,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);

  issue_op_t dec_op;
  issue_op_t out_op;
  issue_op_t skid_op;
  logic      out_valid_q;
  logic      skid_valid;
  logic      in_ready_q;
  logic      accept;
  logic      out_free;

  alu_decode u_decode (
    .instr   (in_instr),
    .pc      (in_pc),
    .rs1     (in_rs1_data),
    .rs2     (in_rs2_data),
    .ctl     (dec_op.ctl),
    .a       (dec_op.a),
    .b       (dec_op.b),
    .rd      (dec_op.rd),
    .illegal (dec_op.illegal)
  );

  assign accept   = in_valid && in_ready_q;
  assign out_free = !out_valid_q || out_ready;

  // in_ready mirrors "skid empty" one cycle late, so a stalled output can absorb exactly one more op
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      skid_valid  <= 1'b0;
      in_ready_q  <= 1'b0;
      out_op      <= '0;
      skid_op     <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      skid_valid  <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (out_free) begin
      if (skid_valid) begin
        out_op      <= skid_op;
        out_valid_q <= 1'b1;
      end else if (accept) begin
        out_op      <= dec_op;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else if (accept) begin
      skid_op    <= dec_op;
      skid_valid <= 1'b1;
      in_ready_q <= 1'b0;
    end else begin
      in_ready_q <= !skid_valid;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_alu_ctl = out_op.ctl;
  assign out_alu_a   = out_op.a;
  assign out_alu_b   = out_op.b;
  assign out_rd      = out_op.rd;
  assign out_illegal = out_op.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed decode vectors, backpressure, flush and reset.
module tb_alu_issue;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [74:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_rs1_data = '0;
  logic [31:0] in_rs2_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_alu_ctl;
  logic [31:0] out_alu_a;
  logic [31:0] out_alu_b;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int n_checks = 0;
  int n_pass = 0;
  logic [74:0] exp_q[$];
  vec_t vecs[16];
  logic sending = 1'b0;

  alu_issue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .in_rs1_data (in_rs1_data),
    .in_rs2_data (in_rs2_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_alu_ctl (out_alu_ctl),
    .out_alu_a   (out_alu_a),
    .out_alu_b   (out_alu_b),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                              input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [4:0] ctl, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd, input logic ill);
    vec_t v;
    v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
    v.exp = {ctl, a, b, rd, ill};
    return v;
  endfunction

  task automatic check(input string name, input logic [74:0] act, input logic [74:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [74:0] payload();
    return {out_alu_ctl, out_alu_a, out_alu_b, out_rd, out_illegal};
  endfunction

  // Monitor: pops one expectation per handshake and checks payload holds while stalled.
  logic        prev_stall = 1'b0;
  logic [74:0] prev_payload = '0;
  always @(negedge clk) begin
    if (rst_n && prev_stall && out_valid) check("stall_stable", payload(), prev_payload);
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_issue: got %h expected no op", payload());
      end else begin
        check("issue", payload(), exp_q.pop_front());
      end
    end
    prev_stall   = rst_n && out_valid && !out_ready;
    prev_payload = payload();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t v);
    logic acc;
    logic done;
    done = 1'b0;
    in_valid = 1'b1; in_instr = v.instr; in_pc = v.pc;
    in_rs1_data = v.rs1; in_rs2_data = v.rs2;
    for (int k = 0; k < 60 && !done; k++) begin
      acc = in_ready;
      step();
      if (acc) begin
        exp_q.push_back(v.exp);
        done = 1'b1;
      end
    end
    if (!done) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready stayed 0 for instr %h", v.instr);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) step();
    check("drain_empty", 75'(exp_q.size()), 75'd0);
  endtask

  initial begin
    logic [15:0] pat;
    pat = 16'b1011_0010_0110_1001;
    vecs[0]  = mk(32'h002081B3, 32'h0,   32'd5,        32'd7,  5'd1,  32'd5,        32'd7,        5'd3,  1'b0);
    vecs[1]  = mk(32'h40435293, 32'h0,   32'h80000000, 32'd0,  5'd10, 32'h80000000, 32'd4,        5'd5,  1'b0);
    vecs[2]  = mk(32'h123450B7, 32'h40,  32'hAAAA,     32'd0,  5'd17, 32'd0,        32'h12345000, 5'd1,  1'b0);
    vecs[3]  = mk(32'h12345097, 32'h100, 32'd0,        32'd0,  5'd18, 32'h100,      32'h12345000, 5'd1,  1'b0);
    vecs[4]  = mk(32'h0000007F, 32'h44,  32'h11,       32'h22, 5'd0,  32'd0,        32'd0,        5'd0,  1'b1);
    vecs[5]  = mk(32'h402081B3, 32'h0,   32'd10,       32'd3,  5'd9,  32'd10,       32'd3,        5'd3,  1'b0);
    vecs[6]  = mk(32'h202081B3, 32'h0,   32'd1,        32'd2,  5'd0,  32'd0,        32'd0,        5'd3,  1'b1);
    vecs[7]  = mk(32'h4020C1B3, 32'h0,   32'd1,        32'd2,  5'd0,  32'd0,        32'd0,        5'd3,  1'b1);
    vecs[8]  = mk(32'hFFF00093, 32'h0,   32'd0,        32'd9,  5'd1,  32'd0,        32'hFFFFFFFF, 5'd1,  1'b0);
    vecs[9]  = mk(32'h00208463, 32'h0,   32'd3,        32'd4,  5'd11, 32'd3,        32'd4,        5'd8,  1'b0);
    vecs[10] = mk(32'h0020F463, 32'h0,   32'd3,        32'd4,  5'd16, 32'd3,        32'd4,        5'd8,  1'b0);
    vecs[11] = mk(32'h0020A463, 32'h0,   32'd3,        32'd4,  5'd0,  32'd0,        32'd0,        5'd8,  1'b1);
    vecs[12] = mk(32'hFE20AE23, 32'h0,   32'h1000,     32'd5,  5'd18, 32'h1000,     32'hFFFFFFFC, 5'd28, 1'b0);
    vecs[13] = mk(32'hFF80A283, 32'h0,   32'h2000,     32'd0,  5'd18, 32'h2000,     32'hFFFFFFF8, 5'd5,  1'b0);
    vecs[14] = mk(32'h008000EF, 32'h200, 32'd7,        32'd8,  5'd18, 32'h200,      32'd4,        5'd1,  1'b0);
    vecs[15] = mk(32'h01F09093, 32'h0,   32'd1,        32'd0,  5'd7,  32'd1,        32'd31,       5'd1,  1'b0);

    // reset state
    repeat (3) step();
    check("rst_out_valid", 75'(out_valid), 75'd0);
    check("rst_in_ready", 75'(in_ready), 75'd0);
    check("rst_payload", payload(), 75'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 75'(in_ready), 75'd1);

    // back-to-back with out_ready held high; first op shows latency 1
    send(vecs[0]);
    check("latency_valid", 75'(out_valid), 75'd1);
    for (int i = 1; i < 16; i++) send(vecs[i]);
    in_valid = 1'b0;
    drain();

    // fixed backpressure pattern while sending everything again
    sending = 1'b1;
    fork
      begin
        for (int i = 0; i < 16; i++) send(vecs[i]);
        in_valid = 1'b0;
        sending = 1'b0;
      end
      begin
        int c;
        c = 0;
        while (sending) begin
          out_ready = pat[c % 16];
          step();
          c++;
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // three back-to-back ops into a stalled output
    out_ready = 1'b0;
    send(vecs[0]);
    send(vecs[1]);
    fork
      send(vecs[5]);
      begin
        check("stall_in_ready", 75'(in_ready), 75'd0);
        repeat (3) begin
          step();
          check("stall_in_ready_hold", 75'(in_ready), 75'd0);
          check("stall_payload", payload(), vecs[0].exp);
        end
        out_ready = 1'b1;
      end
    join
    in_valid = 1'b0;
    drain();

    // flush with both entries full and a request offered
    out_ready = 1'b0;
    send(vecs[2]);
    send(vecs[3]);
    in_valid = 1'b1; in_instr = vecs[4].instr; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    check("flush_out_valid", 75'(out_valid), 75'd0);
    check("flush_in_ready", 75'(in_ready), 75'd1);
    out_ready = 1'b1;
    repeat (3) step();
    check("flush_no_issue", 75'(out_valid), 75'd0);

    // flush discards a same-cycle accepted request
    in_valid = 1'b1; in_instr = vecs[0].instr; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_same_cycle", 75'(out_valid), 75'd0);

    // reset with both entries full and a request offered
    out_ready = 1'b0;
    send(vecs[8]);
    send(vecs[9]);
    in_valid = 1'b1; in_instr = vecs[10].instr; rst_n = 1'b0;
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    exp_q.delete();
    check("mid_rst_out_valid", 75'(out_valid), 75'd0);
    check("mid_rst_in_ready", 75'(in_ready), 75'd0);
    check("mid_rst_payload", payload(), 75'd0);
    step();
    check("after_rst_in_ready", 75'(in_ready), 75'd1);
    out_ready = 1'b1;
    repeat (3) step();
    check("after_rst_no_issue", 75'(out_valid), 75'd0);

    // normal operation resumes after reset
    send(vecs[14]);
    in_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
